// File: rtl/mult_arb_pkg.sv
// Shared types and width helpers for the round-robin multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wdog_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  function automatic int wrap(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[wrap(int'(ptr), k)]) begin
        found                       = 1'b1;
        grant[wrap(int'(ptr), k)]   = 1'b1;
        idx                         = PTR_W'(wrap(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one Multiplier among NREQ requesters: round-robin accept, launch,
// wait for done (with watchdog), then return the product to the granted requester.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int PTR_W   = ptr_width(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_multiplier,
  input  logic [NREQ*WIDTH-1:0]   req_multiplicand,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_error,
  output logic [PTR_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    mult_start,
  output logic [WIDTH-1:0]        mult_multiplier,
  output logic [WIDTH-1:0]        mult_multiplicand,
  input  logic [2*WIDTH-1:0]      mult_product,
  input  logic                    mult_done
);

  localparam int WD_W = wdog_width(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [WD_W-1:0]   wd;
  logic [NREQ-1:0]   pick;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_found;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Gated by rst so every output reads 0 while reset is held.
  assign req_ready = (state == IDLE && rst && pick_found) ? pick : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      ptr               <= '0;
      wd                <= '0;
      grant_id          <= '0;
      busy              <= 1'b0;
      mult_start        <= 1'b0;
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
      rsp_valid         <= '0;
      rsp_product       <= '0;
      rsp_error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            mult_multiplier   <= req_multiplier[int'(pick_idx)*WIDTH +: WIDTH];
            mult_multiplicand <= req_multiplicand[int'(pick_idx)*WIDTH +: WIDTH];
            grant_id          <= pick_idx;
            mult_start        <= 1'b1;
            busy              <= 1'b1;
            state             <= LAUNCH;
          end
        end
        // A stale done from the previous operation may still be high here.
        LAUNCH: begin
          mult_start <= 1'b0;
          wd         <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            rsp_product <= mult_product;
            rsp_error   <= 1'b0;
            rsp_valid   <= ONE << grant_id;
            state       <= RESP;
          end else if (wd == WD_W'(TIMEOUT)) begin
            rsp_product <= '0;
            rsp_error   <= 1'b1;
            rsp_valid   <= ONE << grant_id;
            state       <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            ptr       <= (grant_id == PTR_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a behavioural round-robin model predicts
// each grant and response; a stub multiplier answers with random latency.
module tb_mult_arbiter;

  localparam int WIDTH   = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int PW      = $clog2(NREQ);
  localparam int PW2     = 2 * WIDTH;

  typedef struct {
    int               id;
    logic [PW2-1:0]   prod;
    logic             err;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_multiplier;
  logic [NREQ*WIDTH-1:0] req_multiplicand;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [PW2-1:0]        rsp_product;
  logic                  rsp_error;
  logic [PW-1:0]         grant_id;
  logic                  busy;
  logic                  mult_start;
  logic [WIDTH-1:0]      mult_multiplier;
  logic [WIDTH-1:0]      mult_multiplicand;
  logic [PW2-1:0]        mult_product = '0;
  logic                  mult_done = 1'b0;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   m_ptr = 0;
  int   g_exp;
  exp_t e_cur;
  bit   rand_en = 0, rsp_rand = 0, bp = 0, tmode = 0;
  int   start_cyc = 0, done_cyc = 0, stub_cnt = 0;
  logic rsp_prev = 1'b0, start_prev = 1'b0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_multiplier[g*WIDTH +: WIDTH]   = op_a[g];
    assign req_multiplicand[g*WIDTH +: WIDTH] = op_b[g];
  end

  mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_multiplier    (req_multiplier),
    .req_multiplicand  (req_multiplicand),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_product       (rsp_product),
    .rsp_error         (rsp_error),
    .grant_id          (grant_id),
    .busy              (busy),
    .mult_start        (mult_start),
    .mult_multiplier   (mult_multiplier),
    .mult_multiplicand (mult_multiplicand),
    .mult_product      (mult_product),
    .mult_done         (mult_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic applyStimulus(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_valid[i] = 1'b1;
  endtask

  // One clock: note accepts before the edge, then update requesters after it.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    if (rand_en)
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          applyStimulus(i, WIDTH'($urandom), WIDTH'($urandom));
    if (bp) rsp_ready = '0;
    else if (rsp_rand) rsp_ready = NREQ'($urandom);
    else rsp_ready = '1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((|req_valid || sb.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    checkOutput("drain_budget", 32'(n >= budget), 0);
  endtask

  // Multiplier stub: random latency, plus stray done pulses where they must be ignored.
  always @(negedge clk) begin
    if (!rst) begin
      mult_done = 1'b0;
      stub_cnt  = 0;
    end else begin
      mult_done    = 1'b0;
      mult_product = PW2'($urandom);
      if (mult_start) begin
        stub_cnt = tmode ? 0 : $urandom_range(1, 6);
        if ($urandom_range(1) == 1) mult_done = 1'b1;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          mult_done    = 1'b1;
          mult_product = PW2'(mult_multiplier) * PW2'(mult_multiplicand);
          done_cyc     = cyc;
        end
      end else if ((!busy || |rsp_valid) && $urandom_range(1) == 1) begin
        mult_done = 1'b1;
      end
    end
  end

  // Monitor: predicts grants from the model pointer and checks every response.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      m_ptr      = 0;
      rsp_prev   = 1'b0;
      start_prev = 1'b0;
    end else begin
      checkOutput("ready_with_rsp", 32'(|req_ready && |rsp_valid), 0);
      if (!busy) begin
        g_exp = pick(req_valid, m_ptr);
        checkOutput("req_ready", req_ready, (g_exp < 0) ? 0 : (1 << g_exp));
        if (|(req_valid & req_ready) && g_exp >= 0) begin
          e_cur.id   = g_exp;
          e_cur.err  = tmode;
          e_cur.a    = op_a[g_exp];
          e_cur.b    = op_b[g_exp];
          e_cur.prod = tmode ? '0 : PW2'(op_a[g_exp]) * PW2'(op_b[g_exp]);
          sb.push_back(e_cur);
        end
      end else begin
        checkOutput("ready_while_busy", req_ready, 0);
      end
      if (mult_start) begin
        checkOutput("start_one_cycle", start_prev, 0);
        start_cyc = cyc;
        if (sb.size() != 0) begin
          checkOutput("launch_a", mult_multiplier, sb[$].a);
          checkOutput("launch_b", mult_multiplicand, sb[$].b);
        end
      end
      start_prev = mult_start;
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", rsp_valid, 0);
        end else begin
          e_cur = sb[0];
          checkOutput("rsp_valid", rsp_valid, 1 << e_cur.id);
          checkOutput("rsp_product", rsp_product, e_cur.prod);
          checkOutput("rsp_error", rsp_error, e_cur.err);
          checkOutput("grant_id", grant_id, e_cur.id);
          checkOutput("held_a", mult_multiplier, e_cur.a);
          checkOutput("held_b", mult_multiplicand, e_cur.b);
          // start is seen in LAUNCH, one cycle before WAIT entry
          if (!rsp_prev) begin
            if (e_cur.err) checkOutput("timeout_latency", cyc - start_cyc, TIMEOUT + 2);
            else checkOutput("done_latency", cyc - done_cyc, 1);
          end
          if (rsp_ready[e_cur.id]) begin
            void'(sb.pop_front());
            m_ptr = (e_cur.id + 1) % NREQ;
          end
        end
      end
      rsp_prev = |rsp_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_product"}, rsp_product, 0);
    checkOutput({tag, "_rsp_error"}, rsp_error, 0);
    checkOutput({tag, "_grant_id"}, grant_id, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_mult_start"}, mult_start, 0);
    checkOutput({tag, "_mult_a"}, mult_multiplier, 0);
    checkOutput({tag, "_mult_b"}, mult_multiplicand, 0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rsp_ready = '1;
    rst = 1'b1;

    $display("[TB] all four requesters at once");
    applyStimulus(0, 4'd15, 4'd15);
    applyStimulus(1, 4'd0, 4'd9);
    applyStimulus(2, 4'd1, 4'd7);
    applyStimulus(3, 4'd8, 4'd2);
    drain(300);

    $display("[TB] single request from requester 2");
    applyStimulus(2, 4'd3, 4'd5);
    drain(100);

    $display("[TB] fairness from pointer 3");
    applyStimulus(1, 4'd6, 4'd3);
    applyStimulus(3, 4'd9, 4'd9);
    drain(200);

    $display("[TB] response backpressure");
    bp = 1;
    applyStimulus(0, 4'd7, 4'd9);
    applyStimulus(1, 4'd2, 4'd2);
    repeat (25) step();
    checkOutput("bp_rsp_valid", rsp_valid, 4'b0001);
    checkOutput("bp_pending_held", req_valid[1], 1);
    bp = 0;
    drain(200);

    $display("[TB] watchdog timeout");
    tmode = 1;
    applyStimulus(3, 4'd5, 4'd6);
    drain(300);
    tmode = 0;

    $display("[TB] random traffic");
    rand_en  = 1;
    rsp_rand = 1;
    repeat (800) step();
    rand_en = 0;
    drain(2000);
    rsp_rand = 0;

    $display("[TB] reset during WAIT");
    tmode = 1;
    applyStimulus(1, 4'd4, 4'd4);
    repeat (6) step();
    checkOutput("busy_before_reset", busy, 1);
    applyStimulus(2, 4'd1, 4'd1);
    #1 rst = 1'b0;
    #1 check_all_zero("midreset");
    req_valid = '0;
    tmode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(2, 4'd3, 4'd3);
    applyStimulus(0, 4'd6, 4'd7);
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running, wanted finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `Multiplier` instance among `NREQ` independent requesters. It accepts operand pairs over per-requester valid/ready handshakes, drives the multiplier's `start`/operand inputs, and waits for `productDone`. It then returns the product to the granted requester over a response handshake. A watchdog flags a multiplier that never completes. It sits between client logic and the `Multiplier` top.

## Interface
- `WIDTH`, 4: operand width; product is `2*WIDTH`.
- `NREQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 64: maximum WAIT cycles before an error response, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_multiplier`  in  NREQ*WIDTH  requester i at bits [i*WIDTH +: WIDTH].
- `req_multiplicand`  in  NREQ*WIDTH  same packing.
- `rsp_valid`  out  NREQ  per-requester response valid; at most one bit high.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_product`  out  2*WIDTH  shared response data.
- `rsp_error`  out  1  response is a timeout; product is 0.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `busy`  out  1  high in any state other than IDLE.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_multiplier`, `mult_multiplicand`  out  WIDTH  latched operands.
- `mult_product`  in  2*WIDTH  multiplier product.
- `mult_done`  in  1  multiplier `productDone`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **Reset values** (asserted async while `rst`=0):
  - state=IDLE, all outputs 0, rr pointer `ptr`=0, operand latches 0, watchdog count 0.
- **IDLE**
  - Picker selects the first i with `req_valid[i]`=1, scanning from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[g]`=1 combinationally for the pick only.
  - On `req_valid[g] && req_ready[g]`: latch operands, set `grant_id`=g, go to LAUNCH.
  - No valid requests: stay in IDLE.
- **LAUNCH**
  - `mult_start`=1 for exactly this one cycle; clear watchdog; go to WAIT.
  - `mult_done` is ignored here, because a stale done from the previous operation is possible.
- **WAIT**
  - Watchdog increments each cycle.
  - `mult_done`=1: capture `mult_product` into `rsp_product`, set `rsp_error`=0, go to RESP.
  - Watchdog reaches TIMEOUT with no done: set `rsp_product`=0, `rsp_error`=1, go to RESP.
  - If done and timeout coincide, done wins.
- **RESP**
  - `rsp_valid[g]`=1; hold `rsp_product`/`rsp_error` stable until `rsp_ready[g]`=1.
  - On that handshake: `ptr`=(g+1) mod NREQ; go to IDLE.
  - `rsp_valid` drops the next cycle.
- `mult_multiplier`/`mult_multiplicand` remain stable from LAUNCH through RESP.
- `mult_done` is ignored in IDLE, LAUNCH and RESP. A late done arriving after a timeout is discarded.
- `req_valid` from non-granted requesters is held off and never dropped. Requesters must hold valid and operands until accepted.
- **Reset mid-operation:** returns to reset values immediately; any in-flight result is lost. The arbiter does not reset the multiplier, which shares `rst`.

## Timing
- Request accepted at edge T0 → `mult_start` high during cycle T0+1 → WAIT from T0+2.
- `mult_done` sampled high at edge Tk → `rsp_valid` high from Tk+1.
- Minimum turnaround is 1 cycle: a response handshake at edge Tr allows the next accept at Tr+1.
- `req_ready` and `rsp_valid` are never high in the same cycle.
- Watchdog: error `rsp_valid` appears TIMEOUT+1 cycles after WAIT entry.

## Structure
- Shared package `mult_arb_pkg`:
  - state enum {IDLE, LAUNCH, WAIT, RESP};
  - `PTR_W`=$clog2(NREQ) helper;
  - watchdog width constant `$clog2(TIMEOUT+1)`.
- One sub-module `rr_picker`: combinational, takes `req_valid` and `ptr`, returns a one-hot grant and its index.
- Top of the arbiter is the FSM, latches and watchdog.
- Integration test top instantiates `mult_arbiter` and `Multiplier` with matching WIDTH.

## Test plan
- Single request, requester 2, operands 3×5 → `req_ready[2]` high in IDLE; `mult_start` one cycle; `rsp_valid[2]` with `rsp_product`=15, `rsp_error`=0; `ptr`=3.
- All four requesters valid simultaneously after reset → served in order 0,1,2,3. Operands 15×15, 0×9, 1×7, 8×2 give 225, 0, 7, 16.
- Fairness with `ptr`=3 and requesters 1 and 3 valid → 3 served before 1.
- Backpressure: `rsp_ready` low for 10 cycles → `rsp_valid`/`rsp_product` held stable; no new accept; a pending requester waits.
- Timeout: stub `mult_done` never asserts → after 65 cycles in WAIT, `rsp_error`=1 and `rsp_product`=0. A done pulse injected later in IDLE is ignored. A done asserted during LAUNCH is also ignored.
- `rst` pulled low mid-WAIT → all outputs 0 asynchronously, `ptr`=0. After release, a fresh request is served from requester 0.
